// File: rtl/vga_scan_driver_if.sv
// vga_scan_driver_if: painter inputs, scan coordinates and DAC-side outputs of the raster driver.
interface vga_scan_driver_if;
    logic [23:0] spriteRGB;
    logic        spriteActive;
    logic [23:0] bgRGB;
    logic [9:0]  pixelX;
    logic [9:0]  pixelY;
    logic [7:0]  vgaR;
    logic [7:0]  vgaG;
    logic [7:0]  vgaB;
    logic        hsync;
    logic        vsync;
    logic        blankN;
    logic        syncN;
    logic        vgaClk;
    logic        pixEn;
    logic        frameStart;
    modport master(
        input  spriteRGB, spriteActive, bgRGB,
        output pixelX, pixelY, vgaR, vgaG, vgaB, hsync, vsync, blankN, syncN, vgaClk, pixEn, frameStart
    );
    modport slave(
        output spriteRGB, spriteActive, bgRGB,
        input  pixelX, pixelY, vgaR, vgaG, vgaB, hsync, vsync, blankN, syncN, vgaClk, pixEn, frameStart
    );
endinterface

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster counters plus a registered output stage that composites sprite over background.
module vga_scan_driver #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input logic clk,
    input logic rst,
    vga_scan_driver_if.master vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int DW       = $clog2(CLK_DIV);
    logic [DW-1:0] div_cnt;
    logic [9:0]    h_count;
    logic [9:0]    v_count;
    logic          pix_en;
    logic          h_wrap;
    logic          v_wrap;
    logic          visible;
    logic [23:0]   rgb;
    assign pix_en  = div_cnt == DW'(CLK_DIV - 1);
    assign h_wrap  = h_count == 10'(H_TOTAL - 1);
    assign v_wrap  = v_count == 10'(V_TOTAL - 1);
    assign visible = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));
    assign rgb     = visible ? (vga.spriteActive ? vga.spriteRGB : vga.bgRGB) : 24'h0;
    assign vga.pixelX     = h_count;
    assign vga.pixelY     = v_count;
    assign vga.pixEn      = pix_en;
    assign vga.frameStart = pix_en && h_wrap && v_wrap;
    assign vga.vgaClk     = div_cnt >= DW'(CLK_DIV / 2);
    assign vga.syncN      = 1'b0;
    // Output stage samples the pre-advance counters so sync and colour describe the same pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            h_count    <= '0;
            v_count    <= '0;
            vga.vgaR   <= '0;
            vga.vgaG   <= '0;
            vga.vgaB   <= '0;
            vga.hsync  <= 1'b1;
            vga.vsync  <= 1'b1;
            vga.blankN <= 1'b0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + DW'(1);
            if (pix_en) begin
                h_count <= h_wrap ? '0 : h_count + 10'd1;
                if (h_wrap)
                    v_count <= v_wrap ? '0 : v_count + 10'd1;
                {vga.vgaR, vga.vgaG, vga.vgaB} <= rgb;
                vga.hsync  <= !((h_count >= 10'(HS_START)) && (h_count < 10'(HS_START + H_SYNC)));
                vga.vsync  <= !((v_count >= 10'(VS_START)) && (v_count < 10'(VS_START + V_SYNC)));
                vga.blankN <= visible;
            end
        end
    end
endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster timing generator and pixel output stage for the VGA path. It produces the `pixelX`/`pixelY` scan coordinates that every painter in the design (sprites, background) evaluates combinationally. It samples the painters' `RGB`/`isActive` answers and composites them over a background colour. It drives the DAC-side signals (`vgaR/G/B`, `hsync`, `vsync`, `blankN`, `syncN`, `vgaClk`) with sync and colour aligned on the same registered pixel.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; even, ≥2.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: hsync width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vsync width, lines.
- `V_BP`, 33: vertical back porch, lines.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `spriteRGB`  in  24  colour from the sprite painter, {R,G,B}.
- `spriteActive`  in  1  sprite painter covers the current pixel.
- `bgRGB`  in  24  background colour.
- `pixelX`  out  10  current horizontal count, 0..H_TOTAL-1.
- `pixelY`  out  10  current vertical count, 0..V_TOTAL-1.
- `vgaR`, `vgaG`, `vgaB`  out  8 each  registered colour.
- `hsync`, `vsync`  out  1  registered sync, active-low.
- `blankN`  out  1  registered; 1 inside the visible area.
- `syncN`  out  1  constant 0.
- `vgaClk`  out  1  pixel clock to the DAC.
- `pixEn`  out  1  one-`clk` pulse per pixel.
- `frameStart`  out  1  one-`clk` pulse at frame wrap.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 800 at defaults. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 525 at defaults.
- Divider `divCnt` counts 0..CLK_DIV-1 and wraps.
  - `pixEn` = (`divCnt` == CLK_DIV-1).
  - `vgaClk` = (`divCnt` ≥ CLK_DIV/2). Its rising edge falls mid-way between output updates.
- Counters `hCount`/`vCount` advance only on `pixEn`:
  - `hCount` increments and wraps 799→0.
  - On the h wrap, `vCount` increments and wraps 524→0.
  - `pixelX` = `hCount` and `pixelY` = `vCount` directly. Painters see raw counts; they gate with their own `isActive`.
- Visible = (`hCount` < H_ACTIVE) && (`vCount` < V_ACTIVE).
- Output stage updates on `pixEn`, from the counter values present in that same cycle, before they advance:
  - `hsync` = 0 iff `hCount` ∈ [656, 751]; otherwise 1.
  - `vsync` = 0 iff `vCount` ∈ [490, 491]; otherwise 1.
  - `blankN` = visible.
  - Colour = visible ? (`spriteActive` ? `spriteRGB` : `bgRGB`) : 0.
  - Outside the visible area colour is forced to 0 regardless of `spriteActive`.
- `frameStart` = `pixEn` && `hCount`==799 && `vCount`==524. It is high for one `clk`, in the same cycle the counters wrap to (0,0).
- Output registers hold between `pixEn` pulses.

## Timing
- Reset (`rst`=1 at a `clk` edge), applied in the same edge regardless of state:
  - `divCnt`, `hCount`, `vCount` = 0.
  - `vgaR/G/B` = 0, `hsync` = 1, `vsync` = 1, `blankN` = 0, `frameStart` = 0.
- Reset mid-frame aborts the frame; no partial sync pulse is completed.
- First `pixEn` after release: CLK_DIV-1 cycles after the first non-reset edge (cycle 1 for CLK_DIV=2).
- Pixel latency:
  - Painter inputs are sampled on the `pixEn` cycle for the current (`pixelX`,`pixelY`).
  - Outputs show that pixel from the next `clk` edge until the following update, one pixel period.
  - Sync and colour are always mutually aligned.
- Painters are combinational. `spriteRGB`/`spriteActive` must be settled within one `clk` of a counter change, because counters change only on the edge after `pixEn`.
- Periods at defaults with CLK_DIV=2:
  - line = 1600 `clk`.
  - hsync low = 192 `clk`.
  - frame = 840 000 `clk`.
  - vsync low = 2 lines = 3200 `clk`.

## Test plan
- Reset: hold `rst` for 3 cycles, release. During reset, RGB = 0, `hsync`/`vsync`/`vgaClk`… as specified: `hsync` = `vsync` = 1 and `blankN` = 0. The first `pixEn` is at cycle 1 after release.
- Pixel (0,0) with `spriteActive`=1 and `spriteRGB`=24'hFF0000:
  - After the first `pixEn`, `vgaR`=FF, `vgaG`=00, `vgaB`=00, `blankN`=1.
  - With `spriteActive`=0 and `bgRGB`=24'h0000FF, the output is `vgaB`=FF.
- Blanking override: `spriteActive`=1 and `spriteRGB`=FFFFFF held for a full line. Colour is FFFFFF for `hCount` 0..639 and exactly 0 for 640..799.
- Horizontal sync: `hsync` falls at the output update for `hCount`=656 and stays low for exactly 192 `clk`. The line period is 1600 `clk`.
- Vertical sync and frame: `vsync` is low for exactly 3200 `clk` starting at `vCount`=490. `frameStart` pulses exactly once per 840 000 `clk`, coincident with `pixelX`=`pixelY`=0 on the next cycle.
- Reset mid-frame: assert `rst` at `vCount`=300, `hCount`=400 for 1 cycle. Counters are 0 on the next edge and outputs take their reset values. The next `frameStart` comes 840 000 `clk` after release.
